// File: rtl/conv_output_drain_unit_if.sv
// Read-port and result-stream bundle for conv_output_drain_unit.
// master: the drain unit (drives rd_address and the out_* stream).
// slave:  the RAM plus downstream consumer.
interface conv_output_drain_unit_if #(
  parameter int unsigned DATA_BITS                  = 16,
  parameter int unsigned OUTPUT_BUFFER_ADDRESS_BITS = 7,
  parameter int unsigned KERNEL_INDEX_BITS          = 2
);
  logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] rd_address;
  logic [DATA_BITS-1:0]                  rd_data;
  logic [DATA_BITS-1:0]                  out_data;
  logic [KERNEL_INDEX_BITS-1:0]          out_kernel;
  logic                                  out_last;
  logic                                  out_valid;
  logic                                  out_ready;

  modport master (
    output rd_address,
    input  rd_data,
    output out_data,
    output out_kernel,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  rd_address,
    output rd_data,
    input  out_data,
    input  out_kernel,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/conv_output_drain_unit.sv
// conv_output_drain_unit: drains the Conv1D output buffer in kernel-major order
// and streams each word with its kernel index and a last flag.
// A read is committed at the edge where the synchronous RAM samples rd_address,
// and only when the 2-entry skid FIFO (head + skid) can take its data; otherwise
// the address is simply re-presented. This keeps full rate with ready held high.
// Optional feature: define CONV_DRAIN_RELU_EN to clamp negative words to zero.
module conv_output_drain_unit #(
  parameter int unsigned KERNELS                    = 4,
  parameter int unsigned OUTPUTS_PER_KERNEL         = 25,
  parameter int unsigned DATA_BITS                  = 16,
  parameter int unsigned OUTPUT_BUFFER_ADDRESS_BITS = 7,
  parameter int unsigned KERNEL_INDEX_BITS          = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  conv_output_drain_unit_if.master        bus,
  output logic                            busy,
  output logic                            done
);
  localparam int unsigned AW        = OUTPUT_BUFFER_ADDRESS_BITS;
  localparam int unsigned KW        = KERNEL_INDEX_BITS;
  localparam int unsigned PW        = (OUTPUTS_PER_KERNEL > 1) ? $clog2(OUTPUTS_PER_KERNEL) : 1;
  localparam int unsigned LAST_ADDR = KERNELS * OUTPUTS_PER_KERNEL - 1;

  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          rd_address_q;
  logic [PW-1:0]          pos_q;
  logic [KW-1:0]          kern_q;
  logic                   cap_valid_q, cap_last_q;
  logic [KW-1:0]          cap_kernel_q;
  logic                   out_valid_q, out_last_q;
  logic [DATA_BITS-1:0]   out_data_q;
  logic [KW-1:0]          out_kernel_q;
  logic                   skid_valid_q, skid_last_q;
  logic [DATA_BITS-1:0]   skid_data_q;
  logic [KW-1:0]          skid_kernel_q;
  logic                   busy_q, done_q;

  logic                   pop_c, commit_c, finish_c, addr_last_c;
  logic [1:0]             load_c;
  logic [DATA_BITS-1:0]   cap_data_c;

  assign pop_c       = out_valid_q & bus.out_ready;
  // Slots taken after this edge: FIFO entries plus the word landing from RAM, minus a pop.
  assign load_c      = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(cap_valid_q) - 2'(pop_c);
  assign addr_last_c = (rd_address_q == AW'(LAST_ADDR));

`ifdef CONV_DRAIN_RELU_EN
  assign cap_data_c = bus.rd_data[DATA_BITS-1] ? '0 : bus.rd_data;
`else
  assign cap_data_c = bus.rd_data;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and read-commit decision.
  always_comb begin
    state_d  = state_q;
    commit_c = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = READ;
      READ: begin
        commit_c = (load_c < 2'd2);
        if (commit_c && addr_last_c) state_d = FLUSH;
      end
      FLUSH: begin
        if (pop_c && out_last_q) begin
          finish_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address / kernel counters and the in-flight read tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_address_q <= '0;
      pos_q        <= '0;
      kern_q       <= '0;
      cap_valid_q  <= 1'b0;
      cap_kernel_q <= '0;
      cap_last_q   <= 1'b0;
    end else begin
      cap_valid_q <= commit_c;
      if (commit_c) begin
        cap_kernel_q <= kern_q;
        cap_last_q   <= addr_last_c;
      end
      if (state_q == IDLE && start) begin
        rd_address_q <= '0;
        pos_q        <= '0;
        kern_q       <= '0;
      end else if (commit_c && !addr_last_c) begin
        rd_address_q <= rd_address_q + AW'(1);
        if (pos_q == PW'(OUTPUTS_PER_KERNEL - 1)) begin
          pos_q  <= '0;
          kern_q <= kern_q + KW'(1);
        end else begin
          pos_q <= pos_q + PW'(1);
        end
      end
    end
  end

  // Skid FIFO: head register drives out_*, skid holds the overflow word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_kernel_q  <= '0;
      out_last_q    <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_kernel_q <= '0;
      skid_last_q   <= 1'b0;
    end else if (!out_valid_q || pop_c) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        out_kernel_q <= skid_kernel_q;
        out_last_q   <= skid_last_q;
        skid_valid_q <= cap_valid_q;
        if (cap_valid_q) begin
          skid_data_q   <= cap_data_c;
          skid_kernel_q <= cap_kernel_q;
          skid_last_q   <= cap_last_q;
        end
      end else begin
        out_valid_q <= cap_valid_q;
        if (cap_valid_q) begin
          out_data_q   <= cap_data_c;
          out_kernel_q <= cap_kernel_q;
          out_last_q   <= cap_last_q;
        end
      end
    end else if (cap_valid_q) begin
      skid_valid_q  <= 1'b1;
      skid_data_q   <= cap_data_c;
      skid_kernel_q <= cap_kernel_q;
      skid_last_q   <= cap_last_q;
    end
  end

  // Status: busy tracks the FSM, done pulses once the final word is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= finish_c;
    end
  end

  assign bus.rd_address = rd_address_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_kernel = out_kernel_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = out_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule

// File: tb/tb_conv_output_drain_unit.sv
// Bench for conv_output_drain_unit: scoreboard of expected words filled when a
// pass is started, drained by a monitor on every accepted word.
module tb_conv_output_drain_unit;
  localparam int unsigned K     = 4;
  localparam int unsigned P     = 25;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 7;
  localparam int unsigned KW    = 2;
  localparam int          WORDS = K * P;
`ifdef CONV_DRAIN_RELU_EN
  localparam logic [DW-1:0] WORD5 = 16'h0000;
`else
  localparam logic [DW-1:0] WORD5 = 16'hFFF6;
`endif

  logic clk = 1'b0;
  logic rst_n, start, busy, done;
  logic s_start, s_busy, s_done;

  always #5 clk = ~clk;

  conv_output_drain_unit_if #(.DATA_BITS(DW), .OUTPUT_BUFFER_ADDRESS_BITS(AW),
                              .KERNEL_INDEX_BITS(KW)) bus ();
  conv_output_drain_unit_if #(.DATA_BITS(DW), .OUTPUT_BUFFER_ADDRESS_BITS(1),
                              .KERNEL_INDEX_BITS(1)) s_bus ();

  conv_output_drain_unit #(.KERNELS(K), .OUTPUTS_PER_KERNEL(P), .DATA_BITS(DW),
                           .OUTPUT_BUFFER_ADDRESS_BITS(AW), .KERNEL_INDEX_BITS(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus), .busy(busy), .done(done));

  conv_output_drain_unit #(.KERNELS(1), .OUTPUTS_PER_KERNEL(1), .DATA_BITS(DW),
                           .OUTPUT_BUFFER_ADDRESS_BITS(1), .KERNEL_INDEX_BITS(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .start(s_start), .bus(s_bus), .busy(s_busy), .done(s_done));

  // Synchronous output-buffer RAM models.
  logic [DW-1:0] ram [0:127];
  always @(posedge clk) bus.rd_data <= ram[bus.rd_address];
  always @(posedge clk) s_bus.rd_data <= 16'h0ABC ^ 16'(s_bus.rd_address);

  int checks = 0;
  int passed = 0;
  int words_seen = 0;
  logic [DW-1:0] word5_data;
  logic [DW+KW:0] exp_q[$];

  function automatic logic [DW+KW:0] exp_word(input int a);
    logic [DW-1:0] d;
    d = (a == 5) ? WORD5 : DW'(a);
    return {d, KW'(a / P), (a == WORDS - 1)};
  endfunction

  // Monitor: scoreboard compare on every handshake, hold check while stalled.
  logic stall_q = 1'b0;
  logic [DW+KW:0] held;
  always @(negedge clk) begin
    logic [DW+KW:0] got, e;
    got = {bus.out_data, bus.out_kernel, bus.out_last};
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (!bus.out_valid || got !== held)
          $display("FAIL hold_stable valid=%b got=%h required=%h", bus.out_valid, got, held);
        else passed++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_word got=%h required=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e)
            $display("FAIL word%0d got=%h required=%h", words_seen, got, e);
          else passed++;
        end
        if (words_seen == 5) word5_data = bus.out_data;
        words_seen++;
      end
      stall_q = bus.out_valid && !bus.out_ready;
      held    = got;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; s_start = 1'b0;
    bus.out_ready = 1'b1; s_bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.rd_address, bus.out_data, bus.out_kernel, bus.out_last, bus.out_valid} !== '0)
      $display("FAIL reset_outputs got=%h required=0",
               {bus.rd_address, bus.out_data, bus.out_kernel, bus.out_last, bus.out_valid});
    else passed++;
    checks++;
    if ({busy, done, s_busy, s_done, s_bus.out_valid} !== 5'b0)
      $display("FAIL reset_status got=%b required=00000", {busy, done, s_busy, s_done, s_bus.out_valid});
    else passed++;
  endtask

  task automatic test_full_rate();
    int done_at = -1, first_at = -1;
    logic busy_at_done = 1'b1;
    words_seen = 0;
    for (int a = 0; a < WORDS; a++) exp_q.push_back(exp_word(a));
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++;
    if (bus.rd_address !== AW'(0) || busy !== 1'b1)
      $display("FAIL first_address addr=%0d busy=%b required addr=0 busy=1", bus.rd_address, busy);
    else passed++;
    for (int n = 1; n <= 200 && done_at < 0; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid && first_at < 0) first_at = n;
      if (done) begin done_at = n; busy_at_done = busy; end
    end
    checks++;
    if (first_at !== 2) $display("FAIL first_valid_edge got=%0d required=2", first_at);
    else passed++;
    checks++;
    if (done_at !== WORDS + 2) $display("FAIL done_edge got=%0d required=%0d", done_at, WORDS + 2);
    else passed++;
    checks++;
    if (busy_at_done !== 1'b0) $display("FAIL busy_with_done got=%b required=0", busy_at_done);
    else passed++;
    checks++;
    if (words_seen !== WORDS || exp_q.size() != 0)
      $display("FAIL full_rate_count got=%0d left=%0d required=%0d left=0", words_seen, exp_q.size(), WORDS);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) $display("FAIL done_one_cycle got=%b required=0", done);
    else passed++;
  endtask

  task automatic test_relu();
    test_full_rate();
    checks++;
    if (word5_data !== WORD5) $display("FAIL word5_clamp got=%h required=%h", word5_data, WORD5);
    else passed++;
  endtask

  task automatic test_random_ready();
    int done_at = -1;
    words_seen = 0;
    for (int a = 0; a < WORDS; a++) exp_q.push_back(exp_word(a));
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 3000 && done_at < 0; n++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done) done_at = n;
    end
    bus.out_ready = 1'b1;
    checks++;
    if (done_at < 0 || words_seen !== WORDS || exp_q.size() != 0)
      $display("FAIL random_ready done_at=%0d words=%0d left=%0d required words=%0d left=0",
               done_at, words_seen, exp_q.size(), WORDS);
    else passed++;
  endtask

  task automatic test_restart_ignored();
    int done_cnt = 0;
    logic pulsed = 1'b0;
    words_seen = 0;
    for (int a = 0; a < WORDS; a++) exp_q.push_back(exp_word(a));
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 140; n++) begin
      start = 1'b0;
      if (words_seen == 40 && !pulsed) begin start = 1'b1; pulsed = 1'b1; end
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    start = 1'b0;
    checks++;
    if (done_cnt !== 1 || words_seen !== WORDS || exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL restart_ignored dones=%0d words=%0d busy=%b required dones=1 words=%0d busy=0",
               done_cnt, words_seen, busy, WORDS);
    else passed++;
  endtask

  task automatic test_reset_mid_drain();
    words_seen = 0;
    for (int a = 0; a < WORDS; a++) exp_q.push_back(exp_word(a));
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 200 && words_seen < 50; n++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (words_seen < 50) $display("FAIL reach_word50 got=%0d required=50", words_seen);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rd_address, bus.out_data, bus.out_kernel, bus.out_last, bus.out_valid, busy, done} !== '0)
      $display("FAIL reset_mid_drain got=%h required=0",
               {bus.rd_address, bus.out_data, bus.out_kernel, bus.out_last, bus.out_valid, busy, done});
    else passed++;
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_full_rate();
  endtask

  task automatic test_single_word();
    int done_at = -1, first_at = -1;
    logic [DW+1:0] got = '0;
    s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int n = 1; n <= 20 && done_at < 0; n++) begin
      @(posedge clk); #1;
      if (s_bus.out_valid && first_at < 0) begin
        first_at = n;
        got = {s_bus.out_data, s_bus.out_kernel, s_bus.out_last};
      end
      if (s_done) done_at = n;
    end
    checks++;
    if (first_at !== 2 || got !== {16'h0ABC, 1'b0, 1'b1})
      $display("FAIL single_word edge=%0d got=%h required edge=2 word=%h", first_at, got, {16'h0ABC, 2'b01});
    else passed++;
    checks++;
    if (done_at !== 3 || s_busy !== 1'b0)
      $display("FAIL single_done edge=%0d busy=%b required edge=3 busy=0", done_at, s_busy);
    else passed++;
  endtask

  initial begin
    for (int a = 0; a < 128; a++) ram[a] = 16'(a);
    ram[5] = 16'hFFF6;
    test_reset();
    test_full_rate();
    test_relu();
    test_random_ready();
    test_restart_ignored();
    test_reset_mid_drain();
    test_single_word();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/conv_output_drain_unit.md
# conv_output_drain_unit

Drains the Conv1D output buffer after a convolution pass and streams the results out over a valid/ready interface. Issues sequential read addresses to the synchronous output-buffer RAM in kernel-major order, absorbs the one-cycle RAM read latency with a 2-entry skid FIFO, and tags each word with its kernel index and a last flag. It sits on the output buffer's read port, opposite the address generator that fills that buffer.

## Interface
Parameters:
- KERNELS, 4, number of kernels (output channels)
- OUTPUTS_PER_KERNEL, 25, results per kernel; equals ((INPUT_SIZE-KERNEL_SIZE)/STRIDE)+1
- DATA_BITS, 16, signed result width
- OUTPUT_BUFFER_ADDRESS_BITS, 7, output-buffer address width; must hold KERNELS*OUTPUTS_PER_KERNEL-1
- KERNEL_INDEX_BITS, 2, width of out_kernel

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: output buffer complete, begin drain
- rd_address  out  OUTPUT_BUFFER_ADDRESS_BITS  output-buffer read address (registered)
- rd_data  in  DATA_BITS  RAM read data, valid the cycle after rd_address
- out_data  out  DATA_BITS  streamed result
- out_kernel  out  KERNEL_INDEX_BITS  kernel index of out_data
- out_last  out  1  high with the final word of the pass
- out_valid  out  1  out_data/out_kernel/out_last valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- busy  out  1  high from start acceptance until final word accepted
- done  out  1  one-cycle pulse the cycle after final word accepted

## Operation
- Reset: rd_address=0, out_data=0, out_kernel=0, out_last=0, out_valid=0, busy=0, done=0; FIFO empty; state IDLE.
- States: IDLE -> start -> READ; READ -> last address issued -> FLUSH; FLUSH -> final word accepted -> IDLE (done pulses).
- start ignored while busy=1.
- Address order 0..KERNELS*OUTPUTS_PER_KERNEL-1; word at address a has kernel a/OUTPUTS_PER_KERNEL (tracked by counters, no divider).
- Read issued in a cycle only if FIFO occupancy + reads in flight < 2, counting a same-cycle pop as freeing a slot; never overflows, never drops a word.
- rd_data captured into FIFO the cycle after its read; out_* driven from FIFO head.
- out_last asserted only with address KERNELS*OUTPUTS_PER_KERNEL-1.
- Output fields hold stable while out_valid=1 and out_ready=0.
- rst_n low mid-drain: all state and outputs return to reset values immediately; pass abandoned, next start restarts at address 0.

## Timing
- start sampled at edge E0; rd_address=0 valid in cycle after E0; first out_valid in the third cycle after E0 (latency 3).
- With out_ready held high: one word per cycle, 100 words (defaults) in cycles 3..102 after E0; done in cycle 103; busy falls with done.
- out_ready low stalls reads within 2 cycles; restoring out_ready resumes at full rate with no bubble beyond RAM latency.
- Simultaneous pop and capture in one cycle: occupancy unchanged, order preserved.

## Configuration
- CONV_DRAIN_RELU_EN defined: each word is clamped at FIFO capture; negative (MSB=1) values become 0, others pass unchanged.
- Not defined: rd_data passes through unmodified (signed, two's complement).

## Test plan
- Reset then start, out_ready=1, RAM[a]=a: 100 words 0..99, out_kernel 0 for 0..24, 3 for 75..99, out_last only on 99, done in cycle 103 after start.
- out_ready toggled 1-0-0-1 pseudo-randomly: every word delivered exactly once in order, fields stable while stalled, FIFO never exceeds 2.
- start pulsed again at word 40 of a pass: ignored; stream continues to 99, single done.
- rst_n asserted at word 50: outputs zero immediately; new start yields word 0 first.
- RAM[5]=16'hFFF6 (-10): with CONV_DRAIN_RELU_EN word 5 = 0; without it word 5 = 16'hFFF6.
- KERNELS=1, OUTPUTS_PER_KERNEL=1: single word with out_last=1, done 4 cycles after start.
